// File: rtl/mbist_mem_arb.sv
// ---------------------------------------------------------------------------
// mbist_mem_arb
// Shares the MBIST SRAM port between the wishbone burst path (port A) and the
// MBIST engine (port B). Round-robin grant with burst lock, a fairness hold
// limit, and a drain of outstanding reads before every grant hand-over.
// Read returns are tagged so each port sees its own rvalid.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   {a,b}_req/_lock           beat request / burst lock (grant pinned)
//   {a,b}_cs/_addr/_wdata/_we/_wmask   beat payload
//   {a,b}_gnt                 beat accepted this cycle (combinational)
//   {a,b}_rvalid              mem_rdata belongs to this port
//   mem_req/_cs/_addr/_wdata/_we/_wmask  registered SRAM request
//   arb_owner                 01 = A, 10 = B, 00 = none
//
// Optional build macro MBIST_ARB_STAT_EN adds arb_stat_clr (in) and
// arb_wait_cnt[15:0] (out): saturating count of request-without-grant cycles.
// ---------------------------------------------------------------------------
module mbist_mem_arb #(
    parameter int BIST_NO_SRAM = 4,
    parameter int BIST_ADDR_WD = 9,
    parameter int BIST_DATA_WD = 32,
    parameter int RD_LAT       = 2,
    parameter int MAX_HOLD     = 16,
    localparam int CS_WD       = (BIST_NO_SRAM + 1) / 2
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    a_req,
    input  logic                    a_lock,
    input  logic [CS_WD-1:0]        a_cs,
    input  logic [BIST_ADDR_WD-1:0] a_addr,
    input  logic [BIST_DATA_WD-1:0] a_wdata,
    input  logic                    a_we,
    input  logic [3:0]              a_wmask,
    input  logic                    b_req,
    input  logic                    b_lock,
    input  logic [CS_WD-1:0]        b_cs,
    input  logic [BIST_ADDR_WD-1:0] b_addr,
    input  logic [BIST_DATA_WD-1:0] b_wdata,
    input  logic                    b_we,
    input  logic [3:0]              b_wmask,
    output logic                    a_gnt,
    output logic                    b_gnt,
    output logic                    a_rvalid,
    output logic                    b_rvalid,
    output logic                    mem_req,
    output logic [CS_WD-1:0]        mem_cs,
    output logic [BIST_ADDR_WD-1:0] mem_addr,
    output logic [BIST_DATA_WD-1:0] mem_wdata,
    output logic                    mem_we,
    output logic [3:0]              mem_wmask,
`ifdef MBIST_ARB_STAT_EN
    input  logic                    arb_stat_clr,
    output logic [15:0]             arb_wait_cnt,
`endif
    output logic [1:0]              arb_owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN_A = 2'b01,
        ST_OWN_B = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    localparam logic [7:0] MAX_HOLD_V = 8'(MAX_HOLD);

    state_t                    state_q, state_d;
    logic [1:0]                next_owner_q, next_owner_d;
    logic                      last_b_q, last_b_d;   // 1: B was served last
    logic [7:0]                hold_q, hold_d;
    logic [RD_LAT-1:0][1:0]    tag_q, tag_d;         // {B,A} per issued read
    logic [1:0]                mem_port_q, mem_port_d;
    logic                      mem_req_q, mem_req_d;
    logic [CS_WD-1:0]          mem_cs_q, mem_cs_d;
    logic [BIST_ADDR_WD-1:0]   mem_addr_q, mem_addr_d;
    logic [BIST_DATA_WD-1:0]   mem_wdata_q, mem_wdata_d;
    logic                      mem_we_q, mem_we_d;
    logic [3:0]                mem_wmask_q, mem_wmask_d;

    logic rd_issue_s;
    logic pipe_busy_s;
    logic hold_full_s;
    logic a_leave_s;
    logic b_leave_s;
    logic a_gnt_s;
    logic b_gnt_s;

    // Hand-over conditions and outstanding-read status.
    always_comb begin
        // A read is in flight from the cycle mem_req is presented until its
        // tag leaves the pipe output.
        rd_issue_s  = mem_req_q & ~mem_we_q;
        pipe_busy_s = rd_issue_s | (|tag_q);
        hold_full_s = (hold_q == MAX_HOLD_V);
        a_leave_s   = (state_q == ST_OWN_A) & ~a_lock & (~a_req | (hold_full_s & b_req));
        b_leave_s   = (state_q == ST_OWN_B) & ~b_lock & (~b_req | (hold_full_s & a_req));
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            next_owner_q <= 2'b00;
            last_b_q     <= 1'b1;   // makes A the first winner of a tie
            hold_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            next_owner_q <= next_owner_d;
            last_b_q     <= last_b_d;
            hold_q       <= hold_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d      = state_q;
        next_owner_d = next_owner_q;
        last_b_d     = last_b_q;
        case (state_q)
            ST_IDLE: begin
                if (a_req && (!b_req || last_b_q)) begin
                    state_d  = ST_OWN_A;
                    last_b_d = 1'b0;
                end else if (b_req) begin
                    state_d  = ST_OWN_B;
                    last_b_d = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_OWN_A: begin
                if (a_leave_s) begin
                    state_d      = ST_DRAIN;
                    next_owner_d = b_req ? 2'b10 : 2'b00;
                end else begin
                    state_d      = ST_OWN_A;
                end
            end
            ST_OWN_B: begin
                if (b_leave_s) begin
                    state_d      = ST_DRAIN;
                    next_owner_d = a_req ? 2'b01 : 2'b00;
                end else begin
                    state_d      = ST_OWN_B;
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy_s) begin
                    next_owner_d = 2'b00;
                    case (next_owner_q)
                        2'b01: begin
                            state_d  = ST_OWN_A;
                            last_b_d = 1'b0;
                        end
                        2'b10: begin
                            state_d  = ST_OWN_B;
                            last_b_d = 1'b1;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                next_owner_d = 2'b00;
            end
        endcase
    end

    // FSM outputs: grants and current owner.
    always_comb begin
        // The owner is not granted in the cycle it hands the port over.
        a_gnt_s   = (state_q == ST_OWN_A) & a_req & ~a_leave_s;
        b_gnt_s   = (state_q == ST_OWN_B) & b_req & ~b_leave_s;
        case (state_q)
            ST_OWN_A: arb_owner = 2'b01;
            ST_OWN_B: arb_owner = 2'b10;
            default:  arb_owner = 2'b00;
        endcase
    end

    assign a_gnt = a_gnt_s;
    assign b_gnt = b_gnt_s;

    // Hold counter: counts owner beats, saturates, zero outside ownership.
    always_comb begin
        if (a_gnt_s || b_gnt_s) begin
            hold_d = hold_full_s ? hold_q : hold_q + 8'd1;
        end else if ((state_q == ST_OWN_A) || (state_q == ST_OWN_B)) begin
            hold_d = hold_q;
        end else begin
            hold_d = 8'd0;
        end
    end

    // Beat capture into the SRAM request register.
    always_comb begin
        mem_req_d   = 1'b0;
        mem_port_d  = 2'b00;
        mem_cs_d    = mem_cs_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_wmask_d = mem_wmask_q;
        if (a_gnt_s) begin
            mem_req_d   = 1'b1;
            mem_port_d  = 2'b01;
            mem_cs_d    = a_cs;
            mem_addr_d  = a_addr;
            mem_wdata_d = a_wdata;
            mem_we_d    = a_we;
            mem_wmask_d = a_wmask;
        end else if (b_gnt_s) begin
            mem_req_d   = 1'b1;
            mem_port_d  = 2'b10;
            mem_cs_d    = b_cs;
            mem_addr_d  = b_addr;
            mem_wdata_d = b_wdata;
            mem_we_d    = b_we;
            mem_wmask_d = b_wmask;
        end else begin
            mem_req_d   = 1'b0;
        end
    end

    // Read tag pipe: tag enters when the SRAM sees the read, so the last
    // stage lines up with mem_rdata RD_LAT cycles later.
    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = rd_issue_s ? mem_port_q : 2'b00;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // SRAM request and tag pipe registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mem_req_q   <= 1'b0;
            mem_port_q  <= 2'b00;
            mem_cs_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= 4'h0;
            tag_q       <= '0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_port_q  <= mem_port_d;
            mem_cs_q    <= mem_cs_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_wmask_q <= mem_wmask_d;
            tag_q       <= tag_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_cs    = mem_cs_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_wmask = mem_wmask_q;
    assign a_rvalid  = tag_q[RD_LAT-1][0];
    assign b_rvalid  = tag_q[RD_LAT-1][1];

`ifdef MBIST_ARB_STAT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]  wait_inc_s;
    logic [16:0] wait_sum_s;

    // Waiting-cycle counter: +1 per port requesting without a grant.
    always_comb begin
        wait_inc_s = {1'b0, a_req & ~a_gnt_s} + {1'b0, b_req & ~b_gnt_s};
        wait_sum_s = {1'b0, wait_cnt_q} + {15'd0, wait_inc_s};
        if (arb_stat_clr) begin
            wait_cnt_d = 16'd0;
        end else if (wait_sum_s[16]) begin
            wait_cnt_d = 16'hFFFF;
        end else begin
            wait_cnt_d = wait_sum_s[15:0];
        end
    end

    // Waiting-cycle counter register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wait_cnt_q <= 16'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign arb_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_mbist_mem_arb.sv
module tb_mbist_mem_arb;
    localparam int CS_WD = 2, AW = 9, DW = 32, RD_LAT = 2, MAX_HOLD = 16;
    localparam int NRAND = 2000;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i;
    logic a_req, a_lock, a_we, b_req, b_lock, b_we;
    logic [CS_WD-1:0] a_cs, b_cs, mem_cs;
    logic [AW-1:0] a_addr, b_addr, mem_addr;
    logic [DW-1:0] a_wdata, b_wdata, mem_wdata;
    logic [3:0] a_wmask, b_wmask, mem_wmask;
    logic a_gnt, b_gnt, a_rvalid, b_rvalid, mem_req, mem_we;
    logic [1:0] arb_owner;
`ifdef MBIST_ARB_STAT_EN
    logic arb_stat_clr;
    logic [15:0] arb_wait_cnt;
`endif

    mbist_mem_arb #(.BIST_NO_SRAM(4), .BIST_ADDR_WD(AW), .BIST_DATA_WD(DW),
                    .RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .a_req(a_req), .a_lock(a_lock), .a_cs(a_cs), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_we(a_we), .a_wmask(a_wmask),
        .b_req(b_req), .b_lock(b_lock), .b_cs(b_cs), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_we(b_we), .b_wmask(b_wmask),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .mem_req(mem_req), .mem_cs(mem_cs), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_wmask(mem_wmask),
`ifdef MBIST_ARB_STAT_EN
        .arb_stat_clr(arb_stat_clr), .arb_wait_cnt(arb_wait_cnt),
`endif
        .arb_owner(arb_owner));

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_lock = 1'b0; a_cs = '0; a_addr = '0; a_wdata = '0; a_we = 1'b0; a_wmask = 4'h0;
        b_req = 1'b0; b_lock = 1'b0; b_cs = '0; b_addr = '0; b_wdata = '0; b_we = 1'b0; b_wmask = 4'h0;
`ifdef MBIST_ARB_STAT_EN
        arb_stat_clr = 1'b0;
`endif
    endtask

    task automatic next_cyc();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Leaves the bench at posedge+1 with reset released: ready to drive cycle 0.
    task automatic do_reset();
        wb_rst_i = 1'b1;
        idle_inputs();
        next_cyc();
        next_cyc();
        wb_rst_i = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst, a_req, b_req, a_we;
        logic [8:0] a_addr, b_addr;
        logic       e_a_gnt, e_b_gnt;
        logic [1:0] e_owner;
        logic       e_mem_req;
        logic [8:0] e_mem_addr;
    } vec_t;

    function automatic vec_t mk(logic rst, logic ar, logic br, logic awe, logic [8:0] aa, logic [8:0] ba,
                                logic eag, logic ebg, logic [1:0] eo, logic emr, logic [8:0] ema);
        vec_t v;
        v.rst = rst; v.a_req = ar; v.b_req = br; v.a_we = awe; v.a_addr = aa; v.b_addr = ba;
        v.e_a_gnt = eag; v.e_b_gnt = ebg; v.e_owner = eo; v.e_mem_req = emr; v.e_mem_addr = ema;
        return v;
    endfunction

    vec_t tbl[16];

    // ---------------- behavioural reference model ----------------
    int  m_mode;      // 0 idle, 1 A owns, 2 B owns, 3 draining
    int  m_held, m_next, m_last, m_last_rd;
    bit  rv_a[0:NRAND+16];
    bit  rv_b[0:NRAND+16];
    logic e_mreq, e_mwe;
    logic [CS_WD-1:0] e_mcs;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_mwd;
    logic [3:0] e_mwm;

    task automatic model_reset();
        m_mode = 0; m_held = 0; m_next = 0; m_last = 2; m_last_rd = -100;
        for (int i = 0; i <= NRAND + 16; i++) begin rv_a[i] = 1'b0; rv_b[i] = 1'b0; end
        e_mreq = 1'b0; e_mwe = 1'b0; e_mcs = '0; e_maddr = '0; e_mwd = '0; e_mwm = 4'h0;
    endtask

    initial begin
        int a_cnt, b_first;
        bit ga, gb, la, lb, prev_ga, prev_gb;
        int eo;

        idle_inputs();
        wb_rst_i = 1'b1;

        // Table: lone-A write burst, reset, then both requesting from reset.
        tbl[0]  = mk(0,1,0,1,9'h010,9'h000, 0,0,2'b00,0,9'h000);
        tbl[1]  = mk(0,1,0,1,9'h010,9'h000, 1,0,2'b01,0,9'h000);
        tbl[2]  = mk(0,1,0,1,9'h011,9'h000, 1,0,2'b01,1,9'h010);
        tbl[3]  = mk(0,1,0,1,9'h012,9'h000, 1,0,2'b01,1,9'h011);
        tbl[4]  = mk(0,1,0,1,9'h013,9'h000, 1,0,2'b01,1,9'h012);
        tbl[5]  = mk(0,0,0,1,9'h013,9'h000, 0,0,2'b01,1,9'h013);
        tbl[6]  = mk(0,0,0,1,9'h013,9'h000, 0,0,2'b00,0,9'h013);
        tbl[7]  = mk(1,0,0,1,9'h000,9'h000, 0,0,2'b00,0,9'h000);
        tbl[8]  = mk(0,1,1,1,9'h020,9'h030, 0,0,2'b00,0,9'h000);
        tbl[9]  = mk(0,1,1,1,9'h020,9'h030, 1,0,2'b01,0,9'h000);
        tbl[10] = mk(0,0,1,1,9'h020,9'h030, 0,0,2'b01,1,9'h020);
        tbl[11] = mk(0,0,1,1,9'h020,9'h030, 0,0,2'b00,0,9'h020);
        tbl[12] = mk(0,0,1,1,9'h020,9'h030, 0,1,2'b10,0,9'h020);
        tbl[13] = mk(0,0,0,1,9'h020,9'h030, 0,0,2'b10,1,9'h030);
        tbl[14] = mk(0,0,0,1,9'h020,9'h030, 0,0,2'b00,0,9'h030);
        tbl[15] = mk(0,0,0,1,9'h020,9'h030, 0,0,2'b00,0,9'h030);

        // Reset state
        next_cyc();
        @(negedge wb_clk_i);
        check("reset_a_gnt", 64'(a_gnt), 64'd0);
        check("reset_mem_req", 64'(mem_req), 64'd0);
        check("reset_owner", 64'(arb_owner), 64'd0);
        check("reset_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
        do_reset();

        for (int k = 0; k < 16; k++) begin
            wb_rst_i = tbl[k].rst;
            a_req = tbl[k].a_req; b_req = tbl[k].b_req; a_we = tbl[k].a_we; b_we = 1'b1;
            a_addr = tbl[k].a_addr; b_addr = tbl[k].b_addr;
            @(negedge wb_clk_i);
            check($sformatf("tbl%0d_a_gnt", k), 64'(a_gnt), 64'(tbl[k].e_a_gnt));
            check($sformatf("tbl%0d_b_gnt", k), 64'(b_gnt), 64'(tbl[k].e_b_gnt));
            check($sformatf("tbl%0d_owner", k), 64'(arb_owner), 64'(tbl[k].e_owner));
            check($sformatf("tbl%0d_mem_req", k), 64'(mem_req), 64'(tbl[k].e_mem_req));
            check($sformatf("tbl%0d_mem_addr", k), 64'(mem_addr), 64'(tbl[k].e_mem_addr));
            check($sformatf("tbl%0d_rvalid", k), 64'({a_rvalid, b_rvalid}), 64'd0);
            next_cyc();
        end

        // A reads 3 beats while B waits: rvalid 3 cycles after each grant,
        // drain holds through the last rvalid, B granted at cycle 8.
        do_reset();
        b_first = -1;
        for (int c = 0; c < 12; c++) begin
            a_req = (c <= 3); a_we = 1'b0; a_addr = 9'h040 + 9'(c == 0 ? 0 : c - 1);
            b_req = (b_first < 0); b_we = 1'b1; b_addr = 9'h077;
            @(negedge wb_clk_i);
            check($sformatf("rd_a_gnt_c%0d", c), 64'(a_gnt), 64'(c >= 1 && c <= 3));
            check($sformatf("rd_a_rvalid_c%0d", c), 64'(a_rvalid), 64'(c >= 4 && c <= 6));
            check($sformatf("rd_b_rvalid_c%0d", c), 64'(b_rvalid), 64'd0);
            check($sformatf("rd_b_gnt_c%0d", c), 64'(b_gnt), 64'(c == 8));
            if (c >= 2 && c <= 4)
                check($sformatf("rd_mem_addr_c%0d", c), 64'(mem_addr), 64'(9'h040 + 9'(c - 2)));
            if (b_gnt && b_first < 0) b_first = c;
            next_cyc();
        end

        // Hold limit without lock (16 beats) and with lock until cycle 30.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            a_cnt = 0; b_first = -1;
            for (int c = 0; c < 60; c++) begin
                a_req = 1'b1; a_we = 1'b1; a_addr = 9'(c);
                a_lock = (pass == 1) && (c < 30);
                b_req = (b_first < 0); b_we = 1'b1;
                @(negedge wb_clk_i);
                if (b_first < 0 && a_gnt) a_cnt++;
                if (b_first < 0 && b_gnt) b_first = c;
                next_cyc();
            end
            check(pass == 0 ? "hold_a_beats" : "lock_a_beats", 64'(a_cnt), pass == 0 ? 64'd16 : 64'd29);
            check(pass == 0 ? "hold_b_first" : "lock_b_first", 64'(b_first), pass == 0 ? 64'd19 : 64'd32);
            idle_inputs();
        end

        // Reset pulse during OWN_B with reads in flight.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            b_req = 1'b1; b_we = 1'b0; b_addr = 9'h055;
            if (c == 3) begin
                #2 wb_rst_i = 1'b1;
                #1;
                check("rst_async_b_gnt", 64'(b_gnt), 64'd0);
                check("rst_async_owner", 64'(arb_owner), 64'd0);
                check("rst_async_mem", 64'({mem_req, mem_addr}), 64'd0);
                check("rst_async_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
                idle_inputs();
                wb_rst_i = 1'b0;
            end
            next_cyc();
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge wb_clk_i);
            check($sformatf("rst_post_rvalid_c%0d", c), 64'({a_rvalid, b_rvalid}), 64'd0);
            check($sformatf("rst_post_owner_c%0d", c), 64'(arb_owner), 64'd0);
            next_cyc();
        end

`ifdef MBIST_ARB_STAT_EN
        // B waits 10 cycles while A owns under lock.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            a_req = 1'b1; a_lock = 1'b1; a_we = 1'b1;
            b_req = (c >= 2 && c <= 11); b_we = 1'b1;
            arb_stat_clr = (c == 1) || (c == 12);
            @(negedge wb_clk_i);
            if (c == 12) check("stat_wait_cnt", 64'(arb_wait_cnt), 64'd10);
            if (c == 13) check("stat_clr", 64'(arb_wait_cnt), 64'd0);
            next_cyc();
        end
        idle_inputs();
`endif

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        prev_ga = 1'b1; prev_gb = 1'b1;
        for (int c = 0; c < NRAND; c++) begin
            if (!a_req || prev_ga) begin
                a_req = ($urandom % 10) < 6; a_cs = 2'($urandom); a_addr = 9'($urandom);
                a_wdata = $urandom; a_we = 1'($urandom); a_wmask = 4'($urandom);
            end
            if (!b_req || prev_gb) begin
                b_req = ($urandom % 10) < 6; b_cs = 2'($urandom); b_addr = 9'($urandom);
                b_wdata = $urandom; b_we = 1'($urandom); b_wmask = 4'($urandom);
            end
            a_lock = ($urandom % 4) == 0;
            b_lock = ($urandom % 4) == 0;
            @(negedge wb_clk_i);
            la = (m_mode == 1) && !a_lock && (!a_req || (m_held == MAX_HOLD && b_req));
            lb = (m_mode == 2) && !b_lock && (!b_req || (m_held == MAX_HOLD && a_req));
            ga = (m_mode == 1) && a_req && !la;
            gb = (m_mode == 2) && b_req && !lb;
            eo = (m_mode == 1) ? 1 : (m_mode == 2) ? 2 : 0;
            check("rnd_a_gnt", 64'(a_gnt), 64'(ga));
            check("rnd_b_gnt", 64'(b_gnt), 64'(gb));
            check("rnd_owner", 64'(arb_owner), 64'(eo));
            check("rnd_a_rvalid", 64'(a_rvalid), 64'(rv_a[c]));
            check("rnd_b_rvalid", 64'(b_rvalid), 64'(rv_b[c]));
            check("rnd_mem_req", 64'(mem_req), 64'(e_mreq));
            check("rnd_mem_addr", 64'(mem_addr), 64'(e_maddr));
            check("rnd_mem_cs", 64'(mem_cs), 64'(e_mcs));
            check("rnd_mem_wdata", 64'(mem_wdata), 64'(e_mwd));
            check("rnd_mem_we", 64'(mem_we), 64'(e_mwe));
            check("rnd_mem_wmask", 64'(mem_wmask), 64'(e_mwm));
            // Advance the model across the coming clock edge.
            e_mreq = ga | gb;
            if (ga) begin e_mcs = a_cs; e_maddr = a_addr; e_mwd = a_wdata; e_mwe = a_we; e_mwm = a_wmask; end
            if (gb) begin e_mcs = b_cs; e_maddr = b_addr; e_mwd = b_wdata; e_mwe = b_we; e_mwm = b_wmask; end
            if (ga && !a_we) begin m_last_rd = c; rv_a[c + RD_LAT + 1] = 1'b1; end
            if (gb && !b_we) begin m_last_rd = c; rv_b[c + RD_LAT + 1] = 1'b1; end
            if ((ga || gb) && m_held < MAX_HOLD) m_held++;
            case (m_mode)
                0: begin
                    if (a_req && (!b_req || m_last == 2)) begin m_mode = 1; m_last = 1; m_held = 0; end
                    else if (b_req) begin m_mode = 2; m_last = 2; m_held = 0; end
                end
                1: if (la) begin m_mode = 3; m_next = b_req ? 2 : 0; end
                2: if (lb) begin m_mode = 3; m_next = a_req ? 1 : 0; end
                default: begin
                    // Outstanding while any read grant is within RD_LAT+1 cycles.
                    if (m_last_rd < c - (RD_LAT + 1)) begin
                        m_mode = m_next; m_held = 0;
                        if (m_next != 0) m_last = m_next;
                    end
                end
            endcase
            prev_ga = ga; prev_gb = gb;
            next_cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mbist_mem_arb.md
Name: mbist_mem_arb

Overview:
- Two-port arbiter sharing the MBIST SRAM port (mem_req/mem_cs/mem_addr/...) between the wishbone burst path (port A) and the MBIST engine (port B).
- Round-robin grant with burst lock, fairness hold limit, and read-pipeline drain before every grant hand-over.
- Tags read returns per port so each requester sees its own data valid.
- Sits between mbist_wb / BIST engine and the SRAM cs/addr fan-out.

Parameters:
- BIST_NO_SRAM, 4, number of SRAMs; cs width CS_WD = (BIST_NO_SRAM+1)/2
- BIST_ADDR_WD, 9, SRAM word address width
- BIST_DATA_WD, 32, data width
- RD_LAT, 2, SRAM read latency in cycles (issue to rdata valid), range 1..4
- MAX_HOLD, 16, max beats a port keeps the grant without lock while the other port waits, range 1..255

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous reset, active high
- a_req / b_req  in  1  access request, held until granted beat
- a_lock / b_lock  in  1  burst in progress; grant must not move
- a_cs / b_cs  in  CS_WD  SRAM select
- a_addr / b_addr  in  BIST_ADDR_WD  word address
- a_wdata / b_wdata  in  BIST_DATA_WD  write data
- a_we / b_we  in  1  1 = write
- a_wmask / b_wmask  in  4  byte mask
- a_gnt / b_gnt  out  1  beat accepted this cycle
- a_rvalid / b_rvalid  out  1  mem_rdata valid for this port
- mem_req  out  1  SRAM request
- mem_cs  out  CS_WD  SRAM select
- mem_addr  out  BIST_ADDR_WD  address
- mem_wdata  out  BIST_DATA_WD  write data
- mem_we  out  1  write enable
- mem_wmask  out  4  byte mask
- arb_owner  out  2  01 = A, 10 = B, 00 = none

Behaviour:
- Reset: state IDLE, all outputs 0, hold counter 0, read tag pipe cleared. Reset mid-burst drops in-flight rvalids immediately.
- States: IDLE, OWN_A, OWN_B, DRAIN (2-bit next_owner register).
- mem_* are registered, one cycle after the beat. x_gnt is combinational and equals x_req while state = OWN_x; the beat is captured into mem_* on that edge. Else mem_req = 0; other mem_* hold their last values.
- IDLE: a_req wins if only a_req; b_req if only b_req. If both, the port not served last wins; A after reset. Transition to OWN_x; no grant in the IDLE cycle.
- OWN_x: hold counter increments per granted beat, saturating at MAX_HOLD, and clears on entry.
- Leave OWN_x when x_lock = 0 and (x_req = 0, or hold = MAX_HOLD with other port requesting). Go to DRAIN with next_owner = other port if it requests, else none.
- x_lock = 1 pins grant regardless of hold count.
- DRAIN: no grants. Wait until the read tag pipe is empty (no outstanding reads), then go to OWN_next, or IDLE if none. Minimum 1 cycle; RD_LAT cycles after a final read.
- Read tagging: shift pipe, RD_LAT deep, 2-bit tag {B,A} pushed on each issued read (gnt and not we). Writes push 00. x_rvalid = tag at pipe output, aligned with mem_rdata.
- arb_owner reflects OWN_A/OWN_B; 00 in IDLE/DRAIN.
- Simultaneous requests on hand-over: the waiting port is served next even if the old owner re-requests in the same cycle.

Optional Feature:
- MBIST_ARB_STAT_EN.
- Defined: adds output arb_wait_cnt [15:0]. Counts cycles where a port's req = 1 and gnt = 0 (both ports summed, +2 when both wait). Saturates at 0xFFFF. Cleared by reset and by input arb_stat_clr (1 bit, synchronous clear, priority over increment).
- Undefined: neither port exists; no counter logic.

Test Plan:
- Only a_req, 4 write beats, addr 0x010..0x013 -> IDLE one cycle, then a_gnt 4 cycles. mem_req with mem_addr 0x010..0x013 one cycle later, mem_we = 1, arb_owner = 01.
- Both requesting from reset -> A owns first. After A drops req: DRAIN one cycle, then OWN_B; b_gnt first asserts 2 cycles after a_req deasserts.
- A reads 3 beats, b_req pending, RD_LAT = 2 -> a_rvalid asserted exactly 3 cycles after each a_gnt (1 register + 2 SRAM). DRAIN holds until the last a_rvalid; b_rvalid never set for A's reads.
- A continuous requests, no lock, MAX_HOLD = 16, B waiting -> exactly 16 a_gnt, then hand-over to B. Same with a_lock = 1 -> A keeps grant until lock drops.
- wb_rst_i pulse during OWN_B with 2 reads in flight -> all outputs 0 asynchronously, no rvalid after release, state IDLE.
- MBIST_ARB_STAT_EN on: B waits 10 cycles while A owns -> arb_wait_cnt = 10. Pulse arb_stat_clr -> 0 next cycle.
